// File: rtl/timer_bank.sv
// Bank of CHANNELS down-counting interval timers on the J1a IO bus.
// Each channel has a prescaler, periodic/one-shot mode, an IRQ enable and a
// COUNT_HI shadow. Pending flags are write-1-to-clear.

module timer_bank_ch #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        wr_rlo,
   input  logic        wr_rhi,
   input  logic        wr_ctrl,
   input  logic        rd_clo,
   input  logic [15:0] wdata,
   output logic [31:0] reload32,
   output logic [31:0] count32,
   output logic [15:0] ctrl,
   output logic [15:0] shadow,
   output logic        irqen,
   output logic        evt
);
   // Registers are held at 32 bits and masked, so bits above WIDTH are constant 0.
   localparam logic [31:0] MASK = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

   logic [31:0] reload_q, count_q;
   logic        en_q, oneshot_q, irqen_q;
   logic [7:0]  presc_q, pc_q;
   logic [15:0] shadow_q;
   logic [31:0] rlo_new, rhi_new;
   logic        tick, cnt_is1;

   assign rlo_new = {reload_q[31:16], wdata} & MASK;
   assign rhi_new = {wdata, reload_q[15:0]} & MASK;
   assign tick    = en_q && (pc_q == presc_q);
   assign cnt_is1 = (count_q == 32'd1);
   // A RELOAD_HI load on the same edge discards the tick, so no event either.
   assign evt     = tick && cnt_is1 && !wr_rhi;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         reload_q  <= '0;
         count_q   <= '0;
         en_q      <= 1'b0;
         oneshot_q <= 1'b0;
         irqen_q   <= 1'b0;
         presc_q   <= '0;
         pc_q      <= '0;
         shadow_q  <= '0;
      end else begin
         if (wr_rlo) reload_q <= rlo_new;
         if (wr_rhi) reload_q <= rhi_new;

         if (wr_rhi)
            count_q <= rhi_new;
         else if (tick) begin
            if (cnt_is1)
               count_q <= oneshot_q ? 32'd0 : reload_q;
            else if (count_q != 32'd0)
               count_q <= count_q - 32'd1;
         end

         if (wr_ctrl || wr_rhi || !en_q || tick)
            pc_q <= '0;
         else
            pc_q <= pc_q + 8'd1;

         // A CTRL write overrides the one-shot self-disable.
         if (wr_ctrl) begin
            en_q      <= wdata[0];
            oneshot_q <= wdata[1];
            irqen_q   <= wdata[2];
            presc_q   <= wdata[15:8];
         end else if (evt && oneshot_q)
            en_q <= 1'b0;

         // Pre-edge upper half, matching the LO value returned this cycle.
         if (rd_clo) shadow_q <= count_q[31:16];
      end
   end

   assign reload32 = reload_q;
   assign count32  = count_q;
   assign ctrl     = {presc_q, 5'd0, irqen_q, oneshot_q, en_q};
   assign shadow   = shadow_q;
   assign irqen    = irqen_q;
endmodule

module timer_bank #(
   parameter int          CHANNELS  = 4,
   parameter int          WIDTH     = 32,
   parameter logic [15:0] BASE_ADDR = 16'd110
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_wr,
   input  logic        io_rd,
   input  logic [15:0] mem_addr,
   input  logic [15:0] dout,
   output logic [15:0] io_din,
   output logic        irq,
   output logic        irq_pulse
);
   localparam logic [15:0] GLOB = 16'(8 * CHANNELS);

   logic [15:0] off;
   logic [2:0]  k;
   logic        in_ch, glob0, glob1;

   logic [CHANNELS-1:0][31:0] reload32, count32;
   logic [CHANNELS-1:0][15:0] ctrl, shadow;
   logic [CHANNELS-1:0]       evt, irqen, pend_q, w1c;
   logic [CHANNELS-1:0]       wr_rlo, wr_rhi, wr_ctrl, rd_clo;
   logic [1:0]                vld_pipe;
   logic                      irq_q;

   assign off   = mem_addr - BASE_ADDR;
   assign k     = off[2:0];
   assign in_ch = (off < GLOB);
   assign glob0 = (off == GLOB);
   assign glob1 = (off == GLOB + 16'd1);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic sel;
      assign sel        = in_ch && (off[5:3] == 3'(c));
      assign wr_rlo[c]  = io_wr && sel && (k == 3'd0);
      assign wr_rhi[c]  = io_wr && sel && (k == 3'd1);
      assign wr_ctrl[c] = io_wr && sel && (k == 3'd4);
      assign rd_clo[c]  = io_rd && sel && (k == 3'd2);

      timer_bank_ch #(.WIDTH(WIDTH)) u_ch (
         .clk      (clk),
         .resetq   (resetq),
         .wr_rlo   (wr_rlo[c]),
         .wr_rhi   (wr_rhi[c]),
         .wr_ctrl  (wr_ctrl[c]),
         .rd_clo   (rd_clo[c]),
         .wdata    (dout),
         .reload32 (reload32[c]),
         .count32  (count32[c]),
         .ctrl     (ctrl[c]),
         .shadow   (shadow[c]),
         .irqen    (irqen[c]),
         .evt      (evt[c])
      );
   end

   always_comb begin
      io_din = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (in_ch && (off[5:3] == 3'(c))) begin
            case (k)
               3'd0:    io_din = reload32[c][15:0];
               3'd1:    io_din = reload32[c][31:16];
               3'd2:    io_din = count32[c][15:0];
               3'd3:    io_din = shadow[c];
               3'd4:    io_din = ctrl[c];
               default: io_din = '0;
            endcase
         end
      end
      if (glob0) io_din = 16'(pend_q);
      if (glob1) io_din = 16'(pend_q & irqen);
   end

   assign w1c = (io_wr && glob0) ? dout[CHANNELS-1:0] : '0;

   // Pulse goes through two stages so it rises together with irq, one edge after PENDING.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         pend_q   <= '0;
         vld_pipe <= '0;
         irq_q    <= 1'b0;
      end else begin
         pend_q   <= (pend_q & ~w1c) | evt;
         vld_pipe <= {vld_pipe[0], |(evt & irqen)};
         irq_q    <= |(pend_q & irqen);
      end
   end

   assign irq       = irq_q;
   assign irq_pulse = vld_pipe[1];
endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: stimulus queues expected values, a negedge
// monitor pops and compares them against the selected DUT output.

module tb_timer_bank;
   logic        clk = 1'b0;
   logic        resetq = 1'b0;
   logic        io_wr = 1'b0, io_rd = 1'b0;
   logic [15:0] mem_addr = '0, dout = '0;
   logic [15:0] din_a, din_b;
   logic        irq_a, irq_b, pulse_a, pulse_b;

   always #5 clk = ~clk;

   timer_bank #(.CHANNELS(4), .WIDTH(32), .BASE_ADDR(16'd110)) dut_a (
      .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
      .mem_addr(mem_addr), .dout(dout), .io_din(din_a),
      .irq(irq_a), .irq_pulse(pulse_a));

   timer_bank #(.CHANNELS(2), .WIDTH(12), .BASE_ADDR(16'd200)) dut_b (
      .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
      .mem_addr(mem_addr), .dout(dout), .io_din(din_b),
      .irq(irq_b), .irq_pulse(pulse_b));

   // kinds: 0 din_a, 1 irq_a, 2 pulse_a, 3 din_b, 4 irq_b
   typedef struct {
      int          kind;
      logic [15:0] exp;
      string       name;
   } sb_item_t;

   sb_item_t sb[$];
   logic     probe_v = 1'b0;
   int       n_cmp = 0, n_bad = 0;

   always @(negedge clk) begin
      if (probe_v) begin
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: probe with no expected entry");
         end else begin
            sb_item_t it;
            logic [15:0] act;
            it = sb.pop_front();
            case (it.kind)
               0: act = din_a;
               1: act = {15'd0, irq_a};
               2: act = {15'd0, pulse_a};
               3: act = din_b;
               default: act = {15'd0, irq_b};
            endcase
            n_cmp++;
            if (act !== it.exp) begin
               n_bad++;
               $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.exp, $time);
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(logic [15:0] a, logic [15:0] d);
      mem_addr = a; dout = d; io_wr = 1'b1;
      cyc(1);
      io_wr = 1'b0;
   endtask

   task automatic expect_v(int kind, logic [15:0] e, string nm);
      sb_item_t it;
      it.kind = kind; it.exp = e; it.name = nm;
      sb.push_back(it);
      probe_v = 1'b1;
      cyc(1);
      probe_v = 1'b0;
   endtask

   task automatic rd(logic [15:0] a, int kind, logic [15:0] e, string nm);
      mem_addr = a; io_rd = 1'b1;
      expect_v(kind, e, nm);
      io_rd = 1'b0;
   endtask

   initial begin
      cyc(3);
      resetq = 1'b1;
      cyc(1);

      // Reset mid-count: ch0 reload 5 running, reset 3 cycles after load
      wr(16'd110, 16'd5);
      wr(16'd114, 16'h0005);
      wr(16'd111, 16'd0);
      cyc(3);
      resetq = 1'b0;
      cyc(2);
      resetq = 1'b1;
      rd(16'd110, 0, 16'h0000, "rst_reload_lo");
      rd(16'd111, 0, 16'h0000, "rst_reload_hi");
      rd(16'd112, 0, 16'h0000, "rst_count_lo");
      rd(16'd114, 0, 16'h0000, "rst_ctrl");
      rd(16'd142, 0, 16'h0000, "rst_pending");
      expect_v(1, 16'd0, "rst_irq");
      for (int i = 0; i < 100; i++) expect_v(2, 16'd0, "rst_no_pulse");
      rd(16'd142, 0, 16'h0000, "rst_pending_after100");

      // Periodic ch0: reload 5, EN|IRQEN; events at L+5, L+10 -> pulses at L+6, L+11
      wr(16'd110, 16'd5);
      wr(16'd114, 16'h0005);
      wr(16'd111, 16'd0);
      for (int i = 0; i < 12; i++)
         expect_v(2, {15'd0, (i == 6 || i == 11)}, "per_pulse");
      wr(16'd142, 16'h0001);              // clears at L+13
      expect_v(1, 16'd1, "w1c_irq_still");
      expect_v(1, 16'd0, "w1c_irq_drop");
      expect_v(1, 16'd0, "w1c_irq_low");
      expect_v(1, 16'd1, "w1c_irq_reassert");
      // W1C lands on the L+20 event edge
      cyc(2);
      wr(16'd142, 16'h0001);
      rd(16'd142, 0, 16'h0001, "coll_pending_kept");
      expect_v(1, 16'd1, "coll_irq_high");
      wr(16'd114, 16'h0000);
      wr(16'd142, 16'h0001);
      cyc(1);
      expect_v(1, 16'd0, "clr_irq_low");
      rd(16'd142, 0, 16'h0000, "clr_pending");

      // RELOAD_HI write on a tick edge: ch3 ticks every cycle
      wr(16'd134, 16'd10);
      wr(16'd138, 16'h0001);
      wr(16'd135, 16'd0);
      wr(16'd134, 16'd7);
      wr(16'd135, 16'd0);
      rd(16'd136, 0, 16'd7, "rhi_load_wins");
      wr(16'd138, 16'h0000);

      // One-shot ch1: reload 3, prescale 3 -> event at L+12, pulse at L+13
      wr(16'd118, 16'd3);
      wr(16'd122, 16'h0307);
      wr(16'd119, 16'd0);
      for (int i = 0; i < 16; i++)
         expect_v(2, {15'd0, (i == 13)}, "os_pulse");
      rd(16'd122, 0, 16'h0306, "os_ctrl_en_clear");
      rd(16'd120, 0, 16'h0000, "os_count_zero");
      rd(16'd142, 0, 16'h0002, "os_pending");
      for (int i = 0; i < 10; i++) expect_v(2, 16'd0, "os_no_repeat");
      wr(16'd142, 16'h0002);

      // Atomic read ch2: reload 0x0001_0000
      wr(16'd126, 16'd0);
      wr(16'd130, 16'h0001);
      wr(16'd127, 16'd1);
      rd(16'd128, 0, 16'h0000, "atom_lo_zero");
      rd(16'd129, 0, 16'h0001, "atom_hi_shadow");
      rd(16'd128, 0, 16'hFFFE, "atom_lo_after_wrap");
      rd(16'd129, 0, 16'h0000, "atom_hi_shadow2");
      wr(16'd130, 16'h0000);

      // Decode holes
      rd(16'd115, 0, 16'h0000, "hole_k5");
      rd(16'd300, 0, 16'h0000, "outside_block");

      // Width 12 / masking on the 2-channel instance
      wr(16'd200, 16'hFFFF);
      wr(16'd201, 16'hFFFF);
      rd(16'd200, 3, 16'h0FFF, "w12_reload_lo");
      rd(16'd201, 3, 16'h0000, "w12_reload_hi");
      rd(16'd202, 3, 16'h0FFF, "w12_count_lo");
      wr(16'd212, 16'h0004);
      wr(16'd200, 16'd2);
      wr(16'd204, 16'h0001);
      wr(16'd201, 16'd0);
      cyc(4);
      rd(16'd216, 3, 16'h0001, "mask_pending");
      expect_v(4, 16'd0, "mask_irq_low");
      rd(16'd217, 3, 16'h0000, "mask_masked_pending");
      rd(16'd142, 0, 16'h0000, "a_untouched");

      cyc(2);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_leftover: %0d entries left, 0 required", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
